// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline (cpu) vs debug requester with starvation guard and debug burst lock.
// Grants are combinational; read data returns registered one cycle after the grant.
module dmem_arbiter #(
  parameter int N       = 64,
  parameter int AW      = 6,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [N-1:0]  cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [N-1:0]  dbg_addr,
  input  logic [N-1:0]  dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [N-1:0]  dbg_rdata,
  output logic          mem_writeEnable,
  output logic          mem_readEnable,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_writeData,
  input  logic [N-1:0]  mem_readData
);

  typedef enum logic [1:0] {IDLE, CPU, DBG_LOCK} state_t;

  localparam logic [3:0] MAXWAIT_W = 4'(MAXWAIT);

  state_t         state_q, state_d;
  logic [3:0]     dbg_wait_q, dbg_wait_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic           dbg_rvalid_q, dbg_rvalid_d;
  logic [N-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [N-1:0]   dbg_rdata_q, dbg_rdata_d;

  // Only the word-address field of the byte address reaches the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[2:0], cpu_addr[N-1:AW+3],
                              dbg_addr[2:0], dbg_addr[N-1:AW+3]};

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (state_q == DBG_LOCK) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        dbg_gnt = (dbg_wait_q == MAXWAIT_W);
        cpu_gnt = !(dbg_wait_q == MAXWAIT_W);
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_stall = reset && cpu_req && !cpu_gnt;

  always_comb begin
    mem_writeEnable = 1'b0;
    mem_readEnable  = 1'b0;
    mem_addr        = '0;
    mem_writeData   = '0;
    if (cpu_gnt) begin
      mem_writeEnable = cpu_we;
      mem_readEnable  = !cpu_we;
      mem_addr        = cpu_addr[AW+2:3];
      mem_writeData   = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_writeEnable = dbg_we;
      mem_readEnable  = !dbg_we;
      mem_addr        = dbg_addr[AW+2:3];
      mem_writeData   = dbg_wdata;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (dbg_gnt && dbg_lock) begin
      state_d = DBG_LOCK;
    end else if (state_q == DBG_LOCK) begin
      state_d = IDLE;
    end else if (cpu_gnt) begin
      state_d = CPU;
    end

    dbg_wait_d = 4'd0;
    if (dbg_req && !dbg_gnt) begin
      dbg_wait_d = (dbg_wait_q == 4'd15) ? 4'd15 : dbg_wait_q + 4'd1;
    end

    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dbg_rvalid_d = dbg_gnt && !dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_readData : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_readData : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dbg_wait_q   <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dbg_wait_q   <= dbg_wait_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N, default 64, data and address width of both requester ports.
REQ-002 Parameter AW, default 6, memory word-address width; mem_addr is taken from requester addr bits [AW+2:3].
REQ-003 Parameter MAXWAIT, default 4, number of cycles the debug requester is denied before it is forced a grant (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we  in  1 each  pipeline MEM-stage access request and write qualifier.
REQ-007 cpu_addr, cpu_wdata  in  N each  pipeline byte address and store data.
REQ-008 cpu_gnt  out  1  cpu access performed this cycle.
REQ-009 cpu_stall  out  1  equals cpu_req AND NOT cpu_gnt; freezes the pipeline.
REQ-010 cpu_rvalid  out  1, cpu_rdata  out  N  registered read return for the cpu.
REQ-011 dbg_req, dbg_we, dbg_lock  in  1 each  debug/dump request, write qualifier, burst-lock hold.
REQ-012 dbg_addr, dbg_wdata  in  N each  debug byte address and write data.
REQ-013 dbg_gnt  out  1; dbg_rvalid  out  1; dbg_rdata  out  N  debug-side grant and registered read return.
REQ-014 mem_writeEnable, mem_readEnable  out  1 each; mem_addr  out  AW; mem_writeData  out  N  to data memory.
REQ-015 mem_readData  in  N  combinational read data from data memory for the current mem_addr.

Function
REQ-016 The block SHALL hold an owner FSM with states IDLE, CPU, DBG_LOCK, plus a 4-bit saturating counter dbg_wait.
REQ-017 Grants SHALL be combinational from requests and registered state; at most one of cpu_gnt/dbg_gnt is high in any cycle.
REQ-018 Not in DBG_LOCK: only one request high -> that requester is granted.
REQ-019 Not in DBG_LOCK, both high: cpu granted unless dbg_wait == MAXWAIT, in which case dbg granted.
REQ-020 In DBG_LOCK: dbg granted whenever dbg_req is high; cpu never granted.
REQ-021 Transitions: any state -> DBG_LOCK when dbg_gnt and dbg_lock; DBG_LOCK -> IDLE when dbg_lock low or dbg_req low; otherwise -> CPU on cpu_gnt, -> IDLE when no grant.
REQ-022 dbg_wait SHALL increment (saturating at 15) each cycle dbg_req high and dbg_gnt low; clear on dbg_gnt or dbg_req low.
REQ-023 Granted access drives mem_addr, mem_writeData, mem_writeEnable = we, mem_readEnable = NOT we; with no grant, all mem_* outputs are 0.
REQ-024 Granted read SHALL capture mem_readData into that requester's rdata register and assert its rvalid for exactly the next cycle; rdata holds its value until the next read of that requester.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Back-to-back grants to the same requester SHALL sustain one access per cycle.
REQ-027 Request inputs are level-sensitive; a denied requester keeps req and payload stable until granted.

Reset
REQ-028 While reset is low: FSM = IDLE, dbg_wait = 0, rvalids = 0, rdatas = 0; grants and mem_* outputs = 0 regardless of requests.
REQ-029 Reset asserted mid-access SHALL drop that access; no rvalid follows the reset release for it.
REQ-030 The first rising edge after reset release SHALL arbitrate normally from IDLE.

Verification
REQ-031 cpu read only, addr 0x18, mem_readData 0xDEAD -> cpu_gnt same cycle, mem_addr 3, cpu_rvalid next cycle, cpu_rdata 0xDEAD.
REQ-032 cpu_req and dbg_req both held, MAXWAIT 4 -> cpu granted cycles 0-3, dbg granted cycle 4, cpu_stall high cycle 4, dbg_wait 0 at cycle 5.
REQ-033 dbg_lock high, dbg_req held 6 cycles with cpu_req held -> dbg granted all 6 cycles, cpu_stall high throughout, cpu granted cycle 7.
REQ-034 cpu write addr 0x40 data 0x55 -> mem_writeEnable 1, mem_addr 8, mem_writeData 0x55, no cpu_rvalid.
REQ-035 reset low during a granted dbg read -> all outputs 0 next cycle, dbg_rvalid never asserts for it.
REQ-036 Random req/we traffic 10k cycles -> never both grants, no dbg wait above MAXWAIT outside DBG_LOCK, memory model matches a scoreboard.
